// File: rtl/debug_prog_loader.sv
// debug_prog_loader: assembles a framed UART byte stream into 32-bit words and
// writes them to the instruction memory debug port, holding the core meanwhile.
module debug_prog_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [15:0] MAX_WORDS  = 16'hFFFF,
    parameter logic [7:0]  START_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        dbg_sig,
    output logic [31:0] dbg_addr,
    output logic [31:0] dbg_instr,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err
);
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHK, FIN} state_t;
    state_t      state_q;
    logic [15:0] n_q, cnt_q, n_d, cnt_d;
    logic [23:0] word_q;
    logic [1:0]  idx_q;
    logic [7:0]  chk_q, chk_d;
    logic        xfer;
    assign rx_ready = !(state_q == WRITE || state_q == FIN);
    assign xfer     = rx_valid && rx_ready;
    assign chk_d    = chk_q ^ rx_data;
    assign n_d      = {rx_data, n_q[7:0]};
    assign cnt_d    = cnt_q + 16'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            dbg_sig   <= 1'b0;
            dbg_addr  <= BASE_ADDR;
            dbg_instr <= '0;
            core_hold <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            dbg_sig   <= 1'b0;
            load_done <= 1'b0;
            case (state_q)
                IDLE: if (xfer && rx_data == START_BYTE) begin
                    state_q   <= CNT_LO;
                    load_err  <= 1'b0;
                    core_hold <= 1'b1;
                    chk_q     <= '0;
                    cnt_q     <= '0;
                    idx_q     <= '0;
                end
                CNT_LO: if (xfer) begin
                    n_q[7:0] <= rx_data;
                    chk_q    <= chk_d;
                    state_q  <= CNT_HI;
                end
                CNT_HI: if (xfer) begin
                    n_q   <= n_d;
                    chk_q <= chk_d;
                    if (n_d == 16'd0) begin
                        state_q <= CHK;
                    end else if (n_d > MAX_WORDS) begin
                        load_err  <= 1'b1;
                        core_hold <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        state_q <= DATA;
                    end
                end
                // little-endian: each byte shifts in from the top, so byte 0 ends lowest
                DATA: if (xfer) begin
                    chk_q  <= chk_d;
                    word_q <= {rx_data, word_q[23:8]};
                    idx_q  <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q   <= WRITE;
                        dbg_sig   <= 1'b1;
                        dbg_instr <= {rx_data, word_q};
                        dbg_addr  <= BASE_ADDR + 32'(cnt_q);
                    end
                end
                WRITE: begin
                    cnt_q   <= cnt_d;
                    state_q <= (cnt_d == n_q) ? CHK : DATA;
                end
                CHK: if (xfer) begin
                    core_hold <= 1'b0;
                    load_done <= (rx_data == chk_q);
                    load_err  <= (rx_data != chk_q);
                    state_q   <= (rx_data == chk_q) ? FIN : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_prog_loader.sv
// tb_debug_prog_loader: table of load frames driven byte-by-byte; a scoreboard
// queue holds the expected memory writes and is drained by a write monitor.
module tb_debug_prog_loader;
    localparam logic [31:0] BASE = 32'h0;
    logic        clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready, dbg_sig, core_hold, load_done, load_err;
    logic [31:0] dbg_addr, dbg_instr;
    int n_cmp = 0, n_bad = 0;
    logic [63:0] exp_q[$];

    debug_prog_loader dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .dbg_sig(dbg_sig), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
        .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] w [3];
        bit          bad_chk;
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
    } frame_t;
    frame_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && dbg_sig) begin
            if (exp_q.size() == 0) check("unexpected_write", {dbg_addr, dbg_instr}, 64'hx);
            else check("write", {dbg_addr, dbg_instr}, exp_q.pop_front());
        end
    end

    task automatic send(input logic [7:0] b, input bit gaps);
        int t = 0;
        @(negedge clk);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic run_frame(input frame_t f);
        logic [7:0] chk;
        logic [31:0] w;
        chk = f.n[7:0] ^ f.n[15:8];
        send(8'hA5, f.gaps);
        check("hold_after_start", 64'(core_hold), 64'd1);
        send(f.n[7:0], f.gaps);
        send(f.n[15:8], f.gaps);
        for (int i = 0; i < f.n; i++) begin
            w = f.w[i];
            exp_q.push_back({BASE + 32'(i), w});
            for (int k = 0; k < 4; k++) begin
                chk ^= w[8*k +: 8];
                send(w[8*k +: 8], f.gaps);
                if (k < 3) check("hold_in_data", 64'(core_hold), 64'd1);
            end
        end
        send(f.bad_chk ? ~chk : chk, f.gaps);
        check("done_pulse", 64'(load_done), 64'(f.exp_done));
        check("err_flag", 64'(load_err), 64'(f.exp_err));
        check("hold_released", 64'(core_hold), 64'd0);
        check("ready_after_chk", 64'(rx_ready), 64'(!f.exp_done));
        @(posedge clk);
        #1 check("done_one_cycle", 64'(load_done), 64'd0);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, '{32'h00000013, 32'h0, 32'h0}, 0, 0, 1, 0};
        tbl[1] = '{3, '{32'h11111111, 32'h22222222, 32'h33333333}, 0, 0, 1, 0};
        tbl[2] = '{1, '{32'hCAFEF00D, 32'h0, 32'h0}, 1, 0, 0, 1};
        tbl[3] = '{1, '{32'h00000013, 32'h0, 32'h0}, 0, 0, 1, 0};
        tbl[4] = '{0, '{32'h0, 32'h0, 32'h0}, 0, 0, 1, 0};
        tbl[5] = '{2, '{32'hA5A5A5A5, 32'hDEADBEEF, 32'h0}, 0, 1, 1, 0};
        #1;
        check("reset_outputs", {29'd0, dbg_sig, core_hold, load_done, load_err, dbg_addr},
              {29'd0, 4'b0000, BASE});
        check("reset_ready", 64'(rx_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) run_frame(tbl[i]);
        send(8'h33, 0);
        check("stray_byte_dropped", 64'(core_hold), 64'd0);
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        send(8'h00, 0);
        #1 rst = 1'b1;
        #1 check("midframe_reset", {dbg_sig, core_hold, load_done, load_err, rx_ready}, 5'b00001);
        check("midframe_reset_addr", 64'(dbg_addr), 64'(BASE));
        @(negedge clk);
        rst = 1'b0;
        run_frame(tbl[1]);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
